// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester (fetch / data) arbiter in front of a single
// memory port with one outstanding access, a per-access timeout and
// registered outputs.
//
// Optional feature: define MEM_ARB_RR_EN for round-robin contention
// resolution. When it is undefined, the data requester always wins.
//
// Ports
//   I_clk, I_reset                      clock, synchronous active-high reset
//   I_ifreq, I_ifaddr                   fetch request level / word address
//   I_dreq, I_dwe, I_daddr, I_dwdata,   data request level, write enable,
//   I_dbe                               address, write data, byte enables
//   o_ifgnt, o_ifvalid, o_ifrdata,      fetch grant pulse, completion pulse,
//   o_iferr                             read data, timeout flag
//   o_dgnt, o_dvalid, o_drdata, o_derr  same set for the data requester
//   o_mreq, o_mwe, o_maddr, o_mwdata,   memory command (registered)
//   o_mbe
//   I_mack, I_mrdata                    memory acknowledge / read data
//   o_busy                              high whenever an access is in flight
module mem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            I_clk,
  input  logic            I_reset,
  input  logic            I_ifreq,
  input  logic [AW-1:0]   I_ifaddr,
  input  logic            I_dreq,
  input  logic            I_dwe,
  input  logic [AW-1:0]   I_daddr,
  input  logic [DW-1:0]   I_dwdata,
  input  logic [DW/8-1:0] I_dbe,
  output logic            o_ifgnt,
  output logic            o_ifvalid,
  output logic [DW-1:0]   o_ifrdata,
  output logic            o_iferr,
  output logic            o_dgnt,
  output logic            o_dvalid,
  output logic [DW-1:0]   o_drdata,
  output logic            o_derr,
  output logic            o_mreq,
  output logic            o_mwe,
  output logic [AW-1:0]   o_maddr,
  output logic [DW-1:0]   o_mwdata,
  output logic [DW/8-1:0] o_mbe,
  input  logic            I_mack,
  input  logic [DW-1:0]   I_mrdata,
  output logic            o_busy
);

  localparam int unsigned BW = DW / 8;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_ACC = 2'd1,
    D_ACC  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pick_data;

  logic          mreq_d, mwe_d, busy_d;
  logic [AW-1:0] maddr_d;
  logic [DW-1:0] mwdata_d;
  logic [BW-1:0] mbe_d;
  logic          ifgnt_d, ifvalid_d, iferr_d;
  logic          dgnt_d, dvalid_d, derr_d;
  logic [DW-1:0] ifrdata_d, drdata_d;

`ifdef MEM_ARB_RR_EN
  // 1 when the most recent grant went to the data requester
  logic last_data_q, last_data_d;
`endif

  // Contention resolution between the two request levels
`ifdef MEM_ARB_RR_EN
  assign pick_data = I_dreq && (!I_ifreq || !last_data_q);
`else
  assign pick_data = I_dreq;
`endif

  // State register
  always_ff @(posedge I_clk) begin
    if (I_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state and next values of all registered outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mreq_d    = o_mreq;
    mwe_d     = o_mwe;
    maddr_d   = o_maddr;
    mwdata_d  = o_mwdata;
    mbe_d     = o_mbe;
    ifgnt_d   = 1'b0;
    dgnt_d    = 1'b0;
    ifvalid_d = 1'b0;
    dvalid_d  = 1'b0;
    iferr_d   = 1'b0;
    derr_d    = 1'b0;
    ifrdata_d = o_ifrdata;
    drdata_d  = o_drdata;
`ifdef MEM_ARB_RR_EN
    last_data_d = last_data_q;
`endif

    case (state_q)
      IDLE: begin
        // I_mack is deliberately ignored here
        if (pick_data) begin
          state_d  = D_ACC;
          cnt_d    = CW'(1);
          mreq_d   = 1'b1;
          mwe_d    = I_dwe;
          maddr_d  = I_daddr;
          mwdata_d = I_dwdata;
          mbe_d    = I_dbe;
          dgnt_d   = 1'b1;
`ifdef MEM_ARB_RR_EN
          last_data_d = 1'b1;
`endif
        end else if (I_ifreq) begin
          state_d  = IF_ACC;
          cnt_d    = CW'(1);
          mreq_d   = 1'b1;
          mwe_d    = 1'b0;
          maddr_d  = I_ifaddr;
          mwdata_d = '0;
          mbe_d    = '1;
          ifgnt_d  = 1'b1;
`ifdef MEM_ARB_RR_EN
          last_data_d = 1'b0;
`endif
        end
      end

      IF_ACC, D_ACC: begin
        // Ack wins over timeout when both land in the same cycle
        if (I_mack || (cnt_q == CW'(TIMEOUT))) begin
          state_d = IDLE;
          cnt_d   = '0;
          mreq_d  = 1'b0;
          if (state_q == D_ACC) begin
            dvalid_d = 1'b1;
            derr_d   = !I_mack;
            drdata_d = I_mack ? I_mrdata : '0;
          end else begin
            ifvalid_d = 1'b1;
            iferr_d   = !I_mack;
            ifrdata_d = I_mack ? I_mrdata : '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        mreq_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // Output and datapath registers
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      cnt_q     <= '0;
      o_mreq    <= 1'b0;
      o_mwe     <= 1'b0;
      o_maddr   <= '0;
      o_mwdata  <= '0;
      o_mbe     <= '0;
      o_ifgnt   <= 1'b0;
      o_dgnt    <= 1'b0;
      o_ifvalid <= 1'b0;
      o_dvalid  <= 1'b0;
      o_iferr   <= 1'b0;
      o_derr    <= 1'b0;
      o_ifrdata <= '0;
      o_drdata  <= '0;
      o_busy    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_data_q <= 1'b1;
`endif
    end else begin
      cnt_q     <= cnt_d;
      o_mreq    <= mreq_d;
      o_mwe     <= mwe_d;
      o_maddr   <= maddr_d;
      o_mwdata  <= mwdata_d;
      o_mbe     <= mbe_d;
      o_ifgnt   <= ifgnt_d;
      o_dgnt    <= dgnt_d;
      o_ifvalid <= ifvalid_d;
      o_dvalid  <= dvalid_d;
      o_iferr   <= iferr_d;
      o_derr    <= derr_d;
      o_ifrdata <= ifrdata_d;
      o_drdata  <= drdata_d;
      o_busy    <= busy_d;
`ifdef MEM_ARB_RR_EN
      last_data_q <= last_data_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: reset values, a table of single
// accesses, hand-written contention / reset sequences, and a randomized run
// compared against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned TO = 16;

  logic        clk, reset;
  logic        ifreq, dreq, dwe, mack;
  logic [31:0] ifaddr, daddr, dwdata, mrdata;
  logic [3:0]  dbe;
  logic        o_ifgnt, o_ifvalid, o_iferr, o_dgnt, o_dvalid, o_derr;
  logic [31:0] o_ifrdata, o_drdata, o_maddr, o_mwdata;
  logic        o_mreq, o_mwe, o_busy;
  logic [3:0]  o_mbe;

  int n_cmp = 0;
  int n_bad = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .I_clk(clk), .I_reset(reset),
    .I_ifreq(ifreq), .I_ifaddr(ifaddr),
    .I_dreq(dreq), .I_dwe(dwe), .I_daddr(daddr), .I_dwdata(dwdata), .I_dbe(dbe),
    .o_ifgnt(o_ifgnt), .o_ifvalid(o_ifvalid), .o_ifrdata(o_ifrdata), .o_iferr(o_iferr),
    .o_dgnt(o_dgnt), .o_dvalid(o_dvalid), .o_drdata(o_drdata), .o_derr(o_derr),
    .o_mreq(o_mreq), .o_mwe(o_mwe), .o_maddr(o_maddr), .o_mwdata(o_mwdata), .o_mbe(o_mbe),
    .I_mack(mack), .I_mrdata(mrdata), .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Single-access table: ack_at is the o_mreq cycle carrying I_mack (0 = none),
  // exp_valid_at counts clock edges from the edge that samples the request.
  typedef struct {
    bit          d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          ack_at;
    logic [31:0] mrd;
    bit          drop_req;
    int          exp_valid_at;
    bit          exp_err;
    logic [31:0] exp_rdata;
    bit          exp_mwe;
    logic [3:0]  exp_mbe;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] last_if_rd, last_d_rd;

  task automatic apply_vec(input vec_t v, input int idx);
    logic        a_gnt, o_gnt, a_val, a_err;
    logic [31:0] a_rd, o_rd, oth_exp;
    string       tag;
    tag = $sformatf("vec%0d", idx);
    if (v.d) begin
      dreq = 1'b1; dwe = v.we; daddr = v.addr; dwdata = v.wdata; dbe = v.be;
    end else begin
      ifreq = 1'b1; ifaddr = v.addr;
    end
    oth_exp = v.d ? last_if_rd : last_d_rd;
    for (int cyc = 1; cyc <= v.exp_valid_at; cyc++) begin
      @(negedge clk);
      a_gnt = v.d ? o_dgnt : o_ifgnt;     o_gnt = v.d ? o_ifgnt : o_dgnt;
      a_val = v.d ? o_dvalid : o_ifvalid; a_err = v.d ? o_derr : o_iferr;
      a_rd  = v.d ? o_drdata : o_ifrdata; o_rd  = v.d ? o_ifrdata : o_drdata;
      if (cyc == 1) begin
        chk({tag, " gnt"}, a_gnt, 1);
        chk({tag, " other_gnt"}, o_gnt, 0);
      end
      if (cyc < v.exp_valid_at) begin
        chk({tag, " mreq"}, o_mreq, 1);
        chk({tag, " busy"}, o_busy, 1);
        chk({tag, " maddr"}, o_maddr, v.addr);
        chk({tag, " mwe"}, o_mwe, v.exp_mwe);
        chk({tag, " mbe"}, o_mbe, v.exp_mbe);
        if (v.d) chk({tag, " mwdata"}, o_mwdata, v.wdata);
        chk({tag, " early_valid"}, a_val, 0);
      end else begin
        chk({tag, " valid"}, a_val, 1);
        chk({tag, " err"}, a_err, v.exp_err);
        chk({tag, " rdata"}, a_rd, v.exp_rdata);
        chk({tag, " other_rdata_hold"}, o_rd, oth_exp);
        chk({tag, " mreq_clear"}, o_mreq, 0);
        chk({tag, " busy_clear"}, o_busy, 0);
      end
      // Stimulus for the next cycle
      if (cyc == 1) begin
        if (v.d) begin
          daddr = ~v.addr; dwdata = ~v.wdata; dbe = ~v.be; dwe = ~v.we;
          if (v.drop_req) dreq = 1'b0;
        end else begin
          ifaddr = ~v.addr;
          if (v.drop_req) ifreq = 1'b0;
        end
      end
      mack   = (cyc == v.ack_at);
      mrdata = mack ? v.mrd : $urandom;
      if (cyc == v.exp_valid_at) begin
        ifreq = 1'b0; dreq = 1'b0;
        mack = 1'b1; mrdata = 32'h5555_AAAA;   // stray ack while idle
      end
    end
    @(negedge clk);
    chk({tag, " valid_pulse_len"}, v.d ? o_dvalid : o_ifvalid, 0);
    chk({tag, " err_after"}, v.d ? o_derr : o_iferr, 0);
    chk({tag, " idle_ack_ignored"}, {o_mreq, o_busy, o_ifgnt, o_dgnt}, 0);
    mack = 1'b0;
    if (v.d) last_d_rd = v.exp_rdata; else last_if_rd = v.exp_rdata;
  endtask

  // Reference model state (transaction level)
  bit          m_active, m_is_d, m_last_d, m_wd_known;
  int          m_age;
  logic        e_mreq, e_mwe, e_ifgnt, e_dgnt, e_ifvalid, e_dvalid, e_iferr, e_derr, e_busy;
  logic [31:0] e_maddr, e_mwdata, e_ifrdata, e_drdata;
  logic [3:0]  e_mbe;

  task automatic model_step();
    bit          win_d, err;
    logic [31:0] rd;
    {e_ifgnt, e_dgnt, e_ifvalid, e_dvalid, e_iferr, e_derr} = '0;
    if (reset) begin
      m_active = 0; m_age = 0; m_last_d = 1; m_wd_known = 1;
      e_mreq = 0; e_mwe = 0; e_maddr = 0; e_mwdata = 0; e_mbe = 0;
      e_ifrdata = 0; e_drdata = 0;
    end else if (!m_active) begin
      if (ifreq || dreq) begin
`ifdef MEM_ARB_RR_EN
        win_d = dreq && (!ifreq || !m_last_d);
`else
        win_d = dreq;
`endif
        m_active = 1; m_is_d = win_d; m_age = 1; m_last_d = win_d; e_mreq = 1;
        if (win_d) begin
          e_mwe = dwe; e_maddr = daddr; e_mwdata = dwdata; e_mbe = dbe;
          e_dgnt = 1; m_wd_known = 1;
        end else begin
          e_mwe = 0; e_maddr = ifaddr; e_mbe = 4'hF; e_ifgnt = 1; m_wd_known = 0;
        end
      end
    end else if (mack || m_age == TO) begin
      rd = mack ? mrdata : 32'h0;
      err = !mack;
      m_active = 0; e_mreq = 0;
      if (m_is_d) begin e_dvalid = 1; e_derr = err; e_drdata = rd; end
      else begin e_ifvalid = 1; e_iferr = err; e_ifrdata = rd; end
    end else begin
      m_age++;
    end
    e_busy = m_active;
  endtask

  task automatic model_compare();
    chk("rnd mreq", o_mreq, e_mreq);
    chk("rnd mwe", o_mwe, e_mwe);
    chk("rnd maddr", o_maddr, e_maddr);
    if (m_wd_known) chk("rnd mwdata", o_mwdata, e_mwdata);
    chk("rnd mbe", o_mbe, e_mbe);
    chk("rnd gnt", {o_ifgnt, o_dgnt}, {e_ifgnt, e_dgnt});
    chk("rnd valid", {o_ifvalid, o_dvalid}, {e_ifvalid, e_dvalid});
    chk("rnd err", {o_iferr, o_derr}, {e_iferr, e_derr});
    chk("rnd ifrdata", o_ifrdata, e_ifrdata);
    chk("rnd drdata", o_drdata, e_drdata);
    chk("rnd busy", o_busy, e_busy);
  endtask

  initial begin
    bit exp_d[4];
    bit silent;
    reset = 1'b1; ifreq = 0; dreq = 0; dwe = 0; mack = 0;
    ifaddr = 0; daddr = 0; dwdata = 0; dbe = 0; mrdata = 0;
    last_if_rd = 0; last_d_rd = 0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("reset cmd", {o_mreq, o_mwe, o_mbe}, 0);
    chk("reset maddr", o_maddr, 0);
    chk("reset mwdata", o_mwdata, 0);
    chk("reset pulses", {o_ifgnt, o_dgnt, o_ifvalid, o_dvalid, o_iferr, o_derr, o_busy}, 0);
    chk("reset rdata", {o_ifrdata, o_drdata}, 0);
    reset = 1'b0;
    @(negedge clk);

    //          d  we addr          wdata         be    ack mrd           drop vat err rdata         mwe mbe
    vecs[0] = '{0, 0, 32'h0000_0100, 32'h0,        4'h0, 1,  32'hDEAD_BEEF, 0,   2,  0,  32'hDEAD_BEEF, 0,  4'hF};
    vecs[1] = '{1, 1, 32'h0000_0040, 32'h1234_5678, 4'h3, 4,  32'hA5A5_A5A5, 0,   5,  0,  32'hA5A5_A5A5, 1,  4'h3};
    vecs[2] = '{1, 0, 32'h0000_0080, 32'h0,        4'hF, 0,  32'h0,         0,   17, 1,  32'h0,         0,  4'hF};
    vecs[3] = '{1, 0, 32'h0000_00C0, 32'h0,        4'hC, 16, 32'hCAFE_F00D, 0,   17, 0,  32'hCAFE_F00D, 0,  4'hC};
    vecs[4] = '{0, 0, 32'h0000_1000, 32'h0,        4'h0, 3,  32'h0BAD_F00D, 1,   4,  0,  32'h0BAD_F00D, 0,  4'hF};
    vecs[5] = '{0, 0, 32'h0000_2000, 32'h0,        4'h0, 0,  32'h0,         0,   17, 1,  32'h0,         0,  4'hF};
    foreach (vecs[i]) apply_vec(vecs[i], i);

    // Contention from a fresh reset, every access acked in its first cycle
`ifdef MEM_ARB_RR_EN
    exp_d = '{0, 1, 0, 1};
`else
    exp_d = '{1, 1, 1, 1};
`endif
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; last_if_rd = 0; last_d_rd = 0;
    ifreq = 1; ifaddr = 32'h200;
    dreq = 1; dwe = 0; daddr = 32'h300; dwdata = 32'h0; dbe = 4'hF;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k % 2 == 1) begin
        chk($sformatf("cont grant%0d", k / 2), {o_ifgnt, o_dgnt},
            {!exp_d[k / 2], exp_d[k / 2]});
        chk($sformatf("cont mreq%0d", k), o_mreq, 1);
        chk($sformatf("cont maddr%0d", k), o_maddr, exp_d[k / 2] ? 32'h300 : 32'h200);
        mack = 1; mrdata = k;
        if (exp_d[k / 2]) last_d_rd = k; else last_if_rd = k;
      end else begin
        chk($sformatf("cont gap%0d", k), o_mreq, 0);
        chk($sformatf("cont valid%0d", k), {o_ifvalid, o_dvalid},
            {!exp_d[k / 2 - 1], exp_d[k / 2 - 1]});
        mack = 0;
      end
    end
    ifreq = 0; dreq = 0; mack = 0;
    @(negedge clk);
    chk("cont drdata", o_drdata, last_d_rd);
    chk("cont ifrdata", o_ifrdata, last_if_rd);

    // Reset in the middle of a data access, then a late ack
    @(negedge clk);
    dreq = 1; dwe = 0; daddr = 32'h444; dbe = 4'hF;
    repeat (3) @(negedge clk);
    chk("rstmid in_acc", o_mreq, 1);
    reset = 1; dreq = 0;
    @(negedge clk);
    reset = 0;
    chk("rstmid mreq", {o_mreq, o_busy, o_dvalid}, 0);
    @(negedge clk);
    mack = 1; mrdata = 32'h7777_7777;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mack = 0;
      chk($sformatf("rstmid quiet%0d", k), {o_mreq, o_busy, o_dvalid, o_derr, o_dgnt}, 0);
    end
    chk("rstmid drdata", o_drdata, 0);

    // Reset dominates requests and ack
    reset = 1; ifreq = 1; ifaddr = 32'h10; dreq = 1; daddr = 32'h20; mack = 1;
    @(negedge clk);
    chk("rstdom", {o_mreq, o_busy, o_ifgnt, o_dgnt, o_ifvalid, o_dvalid}, 0);
    ifreq = 0; dreq = 0; mack = 0;
    // Randomized run against the reference model, starting from a reset
    model_step();
    reset = 0;
    silent = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      model_compare();
      if (c % 100 == 0) silent = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 299) == 0);
      if (ifreq && e_ifvalid) ifreq = 0;
      if (!ifreq && $urandom_range(0, 2) == 0) begin
        ifreq = 1; ifaddr = $urandom;
      end
      if (dreq && e_dvalid) dreq = 0;
      if (!dreq && $urandom_range(0, 2) == 0) begin
        dreq = 1; dwe = 1'($urandom); daddr = $urandom; dwdata = $urandom; dbe = 4'($urandom);
      end
      mack = !silent && ($urandom_range(0, 3) == 0);
      mrdata = $urandom;
      model_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
